// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIBusy,
    StDBusy
  } arb_state_e;

  typedef enum logic {
    PortI = 1'b0,
    PortD = 1'b1
  } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and backend signals of the memory port arbiter.
// slave: the arbiter's view; master: the view of the stages and backend around it.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_valid;
  logic                  i_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the memory port arbiter.
// Build option ARB_STARVE_GUARD_EN adds the starvation count input.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int unsigned CntW        = 3,
  parameter int unsigned StarveLimit = 4
)
`endif
(
  input  arb_state_e      state_i,
  input  logic            i_eff_i,
  input  logic            d_eff_i,
  input  logic            ack_i,
`ifdef ARB_STARVE_GUARD_EN
  input  logic [CntW-1:0] starve_cnt_i,
`endif
  output logic            launch_o,
  output port_e           port_o
);

  logic starve_hit;

`ifdef ARB_STARVE_GUARD_EN
  assign starve_hit = (starve_cnt_i == CntW'(StarveLimit));
`else
  assign starve_hit = 1'b0;
`endif

  // On an ack edge only the other port may be granted; the served one still
  // shows a stale request until its valid pulse masks it.
  always_comb begin
    launch_o = 1'b0;
    port_o   = PortD;
    unique case (state_i)
      StIdle: begin
        if (i_eff_i && d_eff_i) begin
          launch_o = 1'b1;
          port_o   = starve_hit ? PortI : PortD;
        end else if (d_eff_i) begin
          launch_o = 1'b1;
          port_o   = PortD;
        end else if (i_eff_i) begin
          launch_o = 1'b1;
          port_o   = PortI;
        end
      end
      StIBusy: begin
        if (ack_i && d_eff_i) begin
          launch_o = 1'b1;
          port_o   = PortD;
        end
      end
      StDBusy: begin
        if (ack_i && i_eff_i) begin
          launch_o = 1'b1;
          port_o   = PortI;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (read-only) and data (read/write).
// Data has priority; define ARB_STARVE_GUARD_EN to bound how long fetch can be locked out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BeW = DATA_W / 8;

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e          state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BeW-1:0]      mem_be_q, mem_be_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                i_eff, d_eff;
  logic                launch;
  port_e               port;

  // A port whose valid is high this cycle still shows its old request.
  assign i_eff = bus.i_req & ~i_valid_q;
  assign d_eff = bus.d_req & ~d_valid_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if ((launch && port == PortI) || !i_eff) begin
      starve_cnt_d = '0;
    end else if (launch && port == PortD && starve_cnt_q != CntW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_arb_pick #(
    .CntW        (CntW),
    .StarveLimit (STARVE_LIMIT)
  ) u_pick (
    .state_i      (state_q),
    .i_eff_i      (i_eff),
    .d_eff_i      (d_eff),
    .ack_i        (bus.mem_ack),
    .starve_cnt_i (starve_cnt_q),
    .launch_o     (launch),
    .port_o       (port)
  );
`else
  mem_arb_pick u_pick (
    .state_i  (state_q),
    .i_eff_i  (i_eff),
    .d_eff_i  (d_eff),
    .ack_i    (bus.mem_ack),
    .launch_o (launch),
    .port_o   (port)
  );
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_valid_d   = (state_q == StIBusy) && bus.mem_ack;
    d_valid_d   = (state_q == StDBusy) && bus.mem_ack;
    i_rdata_d   = i_valid_d ? bus.mem_rdata : i_rdata_q;
    // Write completions leave the last read result in place.
    d_rdata_d   = (d_valid_d && !mem_we_q) ? bus.mem_rdata : d_rdata_q;

    if (launch) begin
      if (port == PortI) begin
        state_d     = StIBusy;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
        mem_be_d    = '1;
      end else begin
        state_d     = StDBusy;
        mem_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_be_d    = bus.d_be;
      end
    end else if (state_q != StIdle && bus.mem_ack) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = (state_q != StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req & ~i_valid_q;
  assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner case, then random traffic
// against a transaction-level model of the port ownership.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } ins_t;

  typedef struct {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        i_stall;
    logic        d_stall;
    logic        busy;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t out;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  function automatic ins_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                 logic [31:0] dd, logic [3:0] db, logic ak, logic [31:0] rd);
    ins_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dd; v.d_be = db; v.mem_ack = ak; v.mem_rdata = rd;
    return v;
  endfunction

  function automatic outs_t mk_out(logic rq, logic we, logic [31:0] a, logic [31:0] wd,
                                   logic [3:0] be, logic iv, logic [31:0] ird, logic dv,
                                   logic [31:0] drd, logic is, logic ds, logic bz);
    outs_t o;
    o.mem_req = rq; o.mem_we = we; o.mem_addr = a; o.mem_wdata = wd; o.mem_be = be;
    o.i_valid = iv; o.i_rdata = ird; o.d_valid = dv; o.d_rdata = drd;
    o.i_stall = is; o.d_stall = ds; o.busy = bz;
    return o;
  endfunction

  task automatic drive(input ins_t v);
    bus.i_req     = v.i_req;
    bus.i_addr    = v.i_addr;
    bus.d_req     = v.d_req;
    bus.d_we      = v.d_we;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.d_be      = v.d_be;
    bus.mem_ack   = v.mem_ack;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t e);
    chk({tag, ".mem_req"},   32'(bus.mem_req),   32'(e.mem_req));
    chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(e.mem_we));
    chk({tag, ".mem_addr"},  bus.mem_addr,       e.mem_addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      e.mem_wdata);
    chk({tag, ".mem_be"},    32'(bus.mem_be),    32'(e.mem_be));
    chk({tag, ".i_valid"},   32'(bus.i_valid),   32'(e.i_valid));
    chk({tag, ".i_rdata"},   bus.i_rdata,        e.i_rdata);
    chk({tag, ".d_valid"},   32'(bus.d_valid),   32'(e.d_valid));
    chk({tag, ".d_rdata"},   bus.d_rdata,        e.d_rdata);
    chk({tag, ".i_stall"},   32'(bus.i_stall),   32'(e.i_stall));
    chk({tag, ".d_stall"},   32'(bus.d_stall),   32'(e.d_stall));
    chk({tag, ".busy"},      32'(bus.busy),      32'(e.busy));
  endtask

  localparam int NV = 16;
  vec_t tbl[NV];

  // Transaction-level model state: who owns the backend and what each port last saw.
  int          own;        // 0 none, 1 fetch, 2 data
  logic        e_we, e_iv, e_dv;
  logic [31:0] e_addr, e_wdata, e_ird, e_drd;
  logic [3:0]  e_be;
  int          starve, wait_left;

  initial begin
    ins_t  z;
    outs_t o;
    z = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single fetch with 3 wait cycles, then an ack while idle.
    tbl[0]  = '{mk_in(1, 'h40, 0, 0, 0, 0, 0, 0, 0),
                mk_out(1, 0, 'h40, 0, 'hF, 0, 0, 0, 0, 1, 0, 1)};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[0];
    tbl[4]  = '{mk_in(1, 'h40, 0, 0, 0, 0, 0, 1, 'h13),
                mk_out(0, 0, 'h40, 0, 'hF, 1, 'h13, 0, 0, 0, 0, 0)};
    tbl[5]  = '{z, mk_out(0, 0, 'h40, 0, 'hF, 0, 'h13, 0, 0, 0, 0, 0)};
    tbl[6]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF_FFFF),
                mk_out(0, 0, 'h40, 0, 'hF, 0, 'h13, 0, 0, 0, 0, 0)};
    // Write held through two wait cycles.
    tbl[7]  = '{mk_in(0, 0, 1, 1, 'h200, 'hDEAD_BEEF, 'b0011, 0, 0),
                mk_out(1, 1, 'h200, 'hDEAD_BEEF, 'b0011, 0, 'h13, 0, 0, 0, 1, 1)};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = '{mk_in(0, 0, 1, 1, 'h200, 'hDEAD_BEEF, 'b0011, 1, 'h5555),
                mk_out(0, 1, 'h200, 'hDEAD_BEEF, 'b0011, 0, 'h13, 1, 0, 0, 0, 0)};
    tbl[11] = '{z, mk_out(0, 1, 'h200, 'hDEAD_BEEF, 'b0011, 0, 'h13, 0, 0, 0, 0, 0)};
    // Collision: data first, fetch back-to-back on the data ack.
    tbl[12] = '{mk_in(1, 'h80, 1, 0, 'h100, 0, 'hF, 0, 0),
                mk_out(1, 0, 'h100, 0, 'hF, 0, 'h13, 0, 0, 1, 1, 1)};
    tbl[13] = '{mk_in(1, 'h80, 1, 0, 'h100, 0, 'hF, 1, 'hAAAA_0001),
                mk_out(1, 0, 'h80, 0, 'hF, 0, 'h13, 1, 'hAAAA_0001, 1, 0, 1)};
    tbl[14] = '{mk_in(1, 'h80, 0, 0, 0, 0, 0, 1, 'h0BB),
                mk_out(0, 0, 'h80, 0, 'hF, 1, 'h0BB, 0, 'hAAAA_0001, 0, 0, 0)};
    tbl[15] = '{z, mk_out(0, 0, 'h80, 0, 'hF, 0, 'h0BB, 0, 'hAAAA_0001, 0, 0, 0)};

    drive(z);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("reset", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      drive(tbl[r].in);
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("vec%0d", r), tbl[r].out);
    end

    // Reset in the middle of a data read, then a late ack.
    drive(mk_in(0, 0, 1, 0, 'h300, 0, 'hF, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("abort.pre_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check_outs("abort", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(z);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h77));
    @(posedge clk);
    @(negedge clk);
    check_outs("late_ack", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(z);
    @(posedge clk);
    @(negedge clk);
    check_outs("late_ack2", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic against the model.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    own = 0; e_we = 0; e_iv = 0; e_dv = 0; e_addr = 0; e_wdata = 0; e_ird = 0; e_drd = 0;
    e_be = 0; starve = 0; wait_left = 0;
    begin
      ins_t  in;
      logic  f_act, d_act;
      logic  i_pend, d_pend, n_iv, n_dv;
      int    nown;
      f_act = 0;
      d_act = 0;
      in    = z;
      for (int c = 0; c < 3000; c++) begin
        // Requesters hold fields until their valid pulse, then may start again.
        if (f_act && e_iv) f_act = 0;
        if (!f_act && $urandom_range(0, 2) == 0) begin
          f_act = 1;
          in.i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (d_act && e_dv) d_act = 0;
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_act     = 1;
          in.d_we   = 1'($urandom_range(0, 1));
          in.d_addr = $urandom;
          in.d_wdata = $urandom;
          in.d_be   = 4'($urandom_range(0, 15));
        end
        in.i_req = f_act;
        in.d_req = d_act;
        in.mem_rdata = $urandom;
        if (own != 0) begin
          in.mem_ack = (wait_left == 0);
          if (wait_left > 0) wait_left--;
        end else begin
          in.mem_ack = ($urandom_range(0, 7) == 0);
        end
        drive(in);
        #1;
        o = mk_out(own != 0, e_we, e_addr, e_wdata, e_be, e_iv, e_ird, e_dv, e_drd,
                   in.i_req & ~e_iv, in.d_req & ~e_dv, own != 0);
        check_outs($sformatf("rnd%0d", c), o);

        // Next-edge model: a served port completes, the other pending one may take over.
        i_pend = in.i_req & ~e_iv;
        d_pend = in.d_req & ~e_dv;
        n_iv   = (own == 1) && in.mem_ack;
        n_dv   = (own == 2) && in.mem_ack;
        if (n_iv) e_ird = in.mem_rdata;
        if (n_dv && !e_we) e_drd = in.mem_rdata;
        nown = own;
        if (own == 0) begin
          if (i_pend && d_pend) nown = (Guard && starve == LIMIT) ? 1 : 2;
          else if (d_pend) nown = 2;
          else if (i_pend) nown = 1;
        end else if (in.mem_ack) begin
          if (own == 1 && d_pend) nown = 2;
          else if (own == 2 && i_pend) nown = 1;
          else nown = 0;
        end
        if (nown != 0 && (own == 0 || in.mem_ack)) begin
          if (nown == 1) begin
            e_we = 0; e_addr = in.i_addr; e_wdata = 0; e_be = 4'hF;
          end else begin
            e_we = in.d_we; e_addr = in.d_addr; e_wdata = in.d_wdata; e_be = in.d_be;
          end
          wait_left = $urandom_range(0, 3);
          if (nown == 1) starve = 0;
          else if (!i_pend) starve = 0;
          else if (starve < LIMIT) starve++;
        end else if (!i_pend) begin
          starve = 0;
        end
        own  = nown;
        e_iv = n_iv;
        e_dv = n_dv;
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
